// File: rtl/vga_scan_counter.sv
// Horizontal/vertical VGA scan counter with programmable, frame-aligned totals and a start/stop run FSM.
// Optional VGA_SCAN_FRAME_CNT_EN adds a 16-bit wrapping frame counter output.
module vga_scan_counter #(
  parameter int WIDTH       = 11,
  parameter int H_TOTAL_DEF = 800,
  parameter int V_TOTAL_DEF = 525
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_sel,
  input  logic [WIDTH-1:0] cfg_data,
  output logic [WIDTH-1:0] h_count,
  output logic [WIDTH-1:0] v_count,
  output logic             line_end,
  output logic             frame_end,
  output logic             running
`ifdef VGA_SCAN_FRAME_CNT_EN
  ,output logic [15:0]     frame_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic             running_q, running_d;
  logic [WIDTH-1:0] h_count_q, h_count_d, v_count_q, v_count_d;
  logic [WIDTH-1:0] h_tot_q, h_tot_d, v_tot_q, v_tot_d;
  logic [WIDTH-1:0] h_shd_q, h_shd_d, v_shd_q, v_shd_d;
  logic             pending_q, pending_d;
  logic             line_end_q, line_end_d, frame_end_q, frame_end_d;
  logic             cnt_en, h_wrap, f_wrap, cfg_acc, apply;
  logic [WIDTH-1:0] cfg_clamped;

  // Counting is gated by the registered running flag so the first increment
  // lands one clk after running rises.
  always_comb begin
    cnt_en      = running_q && (state_q != IDLE);
    h_wrap      = cnt_en && pix_en && (h_count_q == h_tot_q - WIDTH'(1));
    f_wrap      = h_wrap && (v_count_q == v_tot_q - WIDTH'(1));
    cfg_acc     = cfg_valid && !pending_q;
    cfg_clamped = (cfg_data < WIDTH'(2)) ? WIDTH'(2) : cfg_data;
    apply       = pending_q && ((state_q == IDLE) || f_wrap);
  end

  always_comb begin
    state_d   = state_q;
    running_d = (state_q != IDLE);
    unique case (state_q)
      IDLE:    if (start && !stop) state_d = RUN;
      RUN:     if (stop) state_d = DRAIN;
      DRAIN: begin
        if (start)       state_d = RUN;
        else if (f_wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    h_count_d   = h_count_q;
    v_count_d   = v_count_q;
    line_end_d  = h_wrap;
    frame_end_d = f_wrap;
    if (cnt_en && pix_en) begin
      h_count_d = h_wrap ? '0 : h_count_q + WIDTH'(1);
      if (h_wrap) v_count_d = f_wrap ? '0 : v_count_q + WIDTH'(1);
    end
  end

  // Only one write may be pending; shadows move to active totals together.
  always_comb begin
    h_shd_d   = h_shd_q;
    v_shd_d   = v_shd_q;
    h_tot_d   = h_tot_q;
    v_tot_d   = v_tot_q;
    pending_d = pending_q;
    if (cfg_acc) begin
      pending_d = 1'b1;
      if (cfg_sel) v_shd_d = cfg_clamped;
      else         h_shd_d = cfg_clamped;
    end else if (apply) begin
      pending_d = 1'b0;
      h_tot_d   = h_shd_q;
      v_tot_d   = v_shd_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      running_q   <= 1'b0;
      h_count_q   <= '0;
      v_count_q   <= '0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      h_tot_q     <= WIDTH'(H_TOTAL_DEF);
      v_tot_q     <= WIDTH'(V_TOTAL_DEF);
      h_shd_q     <= WIDTH'(H_TOTAL_DEF);
      v_shd_q     <= WIDTH'(V_TOTAL_DEF);
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      running_q   <= running_d;
      h_count_q   <= h_count_d;
      v_count_q   <= v_count_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      h_tot_q     <= h_tot_d;
      v_tot_q     <= v_tot_d;
      h_shd_q     <= h_shd_d;
      v_shd_q     <= v_shd_d;
      pending_q   <= pending_d;
    end
  end

  assign cfg_ready = !pending_q;
  assign h_count   = h_count_q;
  assign v_count   = v_count_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;
  assign running   = running_q;

`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (f_wrap) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt_q <= 16'd0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_scan_counter.sv
// Directed bench for vga_scan_counter: config handshake, counting, drain/start, clamp, async reset.
module tb_vga_scan_counter;
  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pix_en = 1'b0, start = 1'b0, stop = 1'b0;
  logic         cfg_valid = 1'b0, cfg_sel = 1'b0;
  logic [W-1:0] cfg_data = '0;
  logic         cfg_ready, line_end, frame_end, running;
  logic [W-1:0] h_count, v_count;
`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [15:0]  frame_count;
`endif

  int checks = 0;
  int errors = 0;

  vga_scan_counter dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .h_count(h_count), .v_count(v_count), .line_end(line_end), .frame_end(frame_end),
    .running(running)
`ifdef VGA_SCAN_FRAME_CNT_EN
    ,.frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic sel, input logic [W-1:0] data);
    cfg_valid = 1'b1; cfg_sel = sel; cfg_data = data;
    tick();
    chk("cfg_ready_drop", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_h", 32'(h_count), 0);
    chk("rst_v", 32'(v_count), 0);
    chk("rst_line_end", 32'(line_end), 0);
    chk("rst_frame_end", 32'(frame_end), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    rst = 1'b0;
    tick();

    // Configure H=4, V=3 in IDLE; each applies on the following clk
    cfg_write(1'b0, 11'd4);
    tick();
    chk("idle_apply_h_ready", 32'(cfg_ready), 1);
    cfg_write(1'b1, 11'd3);
    tick();
    chk("idle_apply_v_ready", 32'(cfg_ready), 1);

    // Start latency: running one clk after start edge, no count yet
    start = 1'b1;
    tick();
    chk("start_running_lag", 32'(running), 0);
    start = 1'b0; pix_en = 1'b1;
    tick();
    chk("start_running", 32'(running), 1);
    chk("start_h0", 32'(h_count), 0);

    // Full-rate frame: 12 pix_en per frame
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("full_h", 32'(h_count), 32'(i % 4));
      chk("full_v", 32'(v_count), 32'((i / 4) % 3));
      chk("full_line_end", 32'(line_end), 32'(i % 4 == 0));
      chk("full_frame_end", 32'(frame_end), 32'(i % 12 == 0));
    end

    // Alternate-clk enable: line_end every 8 clks, still one clk wide
    for (int k = 0; k < 16; k++) begin
      pix_en = (k % 2 == 0);
      tick();
      n = k / 2 + 1;
      chk("alt_h", 32'(h_count), 32'(n % 4));
      chk("alt_v", 32'(v_count), 32'((n / 4) % 3));
      chk("alt_line_end", 32'(line_end), 32'((k % 2 == 0) && (n % 4 == 0)));
    end

    // Mid-frame H=6 write: held pending until the frame wrap
    pix_en = 1'b1;
    cfg_write(1'b0, 11'd6);
    chk("mid_h1", 32'(h_count), 1);
    tick();
    tick();
    chk("mid_h3_old_total", 32'(h_count), 3);
    chk("mid_ready_held", 32'(cfg_ready), 0);
    tick();
    chk("mid_wrap_h", 32'(h_count), 0);
    chk("mid_wrap_frame_end", 32'(frame_end), 1);
    chk("mid_ready_back", 32'(cfg_ready), 1);
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk("newh_h", 32'(h_count), 32'(j));
    end
    tick();
    chk("newh_wrap_h", 32'(h_count), 0);
    chk("newh_wrap_v", 32'(v_count), 1);
    chk("newh_line_end", 32'(line_end), 1);

    // Stop at h=2,v=1: drain to frame end then idle
    tick();
    tick();
    chk("stop_at_h2", 32'(h_count), 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("drain_running", 32'(running), 1);
      chk("drain_no_frame_end", 32'(frame_end), 0);
    end
    tick();
    chk("drain_wrap_frame_end", 32'(frame_end), 1);
    chk("drain_wrap_h", 32'(h_count), 0);
    tick();
    chk("idle_running", 32'(running), 0);
    tick();
    chk("idle_h_hold", 32'(h_count), 0);
    chk("idle_v_hold", 32'(v_count), 0);
`ifdef VGA_SCAN_FRAME_CNT_EN
    chk("frame_count_3", 32'(frame_count), 3);
`endif

    // Start during DRAIN cancels the drain
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("restart_h2", 32'(h_count), 2);
    stop = 1'b1;
    tick();
    stop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("cancel_h4", 32'(h_count), 4);
    repeat (13) tick();
    tick();
    chk("cancel_wrap", 32'(frame_end), 1);
    tick();
    chk("cancel_running", 32'(running), 1);
    chk("cancel_h1", 32'(h_count), 1);

    // Stop again and wait (bounded) for the drain to finish
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n = 0;
    while (frame_end !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("drain2_ticks", 32'(n), 16);
    tick();
    chk("drain2_running", 32'(running), 0);

    // Clamp: H=1 and V=0 both become 2
    cfg_write(1'b0, 11'd1);
    tick();
    cfg_write(1'b1, 11'd0);
    tick();
`ifdef VGA_SCAN_FRAME_CNT_EN
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("clamp_h", 32'(h_count), 32'(i % 2));
      chk("clamp_v", 32'(v_count), 32'((i / 2) % 2));
      chk("clamp_frame_end", 32'(frame_end), 32'(i % 4 == 0));
`ifdef VGA_SCAN_FRAME_CNT_EN
      if (i == 4) chk("frame_count_wrap", 32'(frame_count), 0);
`endif
    end

    // Async reset mid-frame with a pending config
    cfg_write(1'b1, 11'd9);
    chk("pre_rst_h", 32'(h_count), 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_h", 32'(h_count), 0);
    chk("arst_v", 32'(v_count), 0);
    chk("arst_running", 32'(running), 0);
    chk("arst_cfg_ready", 32'(cfg_ready), 1);
`ifdef VGA_SCAN_FRAME_CNT_EN
    chk("arst_frame_count", 32'(frame_count), 0);
`endif
    tick();
    rst = 1'b0;

    // Default H total after reset is 800
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n = 0;
    while (line_end !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk("default_h_total", 32'(n), 800);
    chk("default_v_after_line", 32'(v_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
